// File: rtl/pwm_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_pkg
//  Description : Shared types and sizing helpers for the multi-channel PWM
//                generator (load FSM states, index/prescaler widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_multi_pkg;

    // Load-port state machine: idle, accepting a frame, frame waiting for commit
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } load_state_t;

    // Width of a counter able to hold 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pwm_multi_pkg
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM compare unit: active duty register, magnitude compare
//                against the shared period counter, registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] duty_in,
    input  logic [DWIDTH-1:0] cnt,
    output logic              out
);

    logic [DWIDTH-1:0] r_active;
    logic              r_out;

    // Active duty word, replaced only when the shadow bank is committed
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active <= '0;
        end else if (load) begin
            r_active <= duty_in;
        end
    end

    // Output is high while the counter is below the duty word
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= (cnt < r_active);
        end
    end

    assign out = r_out;

endmodule : pwm_channel
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi
//  Description : Multi-channel PWM generator. Duty words are loaded serially
//                into a shadow bank and committed to the active bank only at
//                a period boundary. Shared prescaler and period counter.
//                Build option PWM_CENTER_ALIGN_EN selects an up/down
//                (centre-aligned) counter instead of the default sawtooth.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int CHANNELS = 8,
    parameter int CLK_DIV  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DWIDTH-1:0]   data,
    input  logic                data_valid,
    output logic                load_ready,
    output logic                commit,
    output logic                period_start,
    output logic [CHANNELS-1:0] out
);

    localparam int                  c_idx_w      = idx_width(CHANNELS);
    localparam int                  c_presc_w    = idx_width(CLK_DIV);
    localparam logic [c_idx_w-1:0]  c_idx_last   = c_idx_w'(CHANNELS - 1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_DIV - 1);
    localparam logic [DWIDTH-1:0]   c_cnt_max    = '1;

    logic [c_presc_w-1:0] r_presc;
    logic [DWIDTH-1:0]    r_cnt;
    logic                 w_tick;
    logic                 w_wrap;
    logic                 r_period_start;

    load_state_t          r_state;
    load_state_t          w_state_nxt;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_idx_w-1:0]   w_idx_nxt;
    logic                 w_wr_en;
    logic                 w_commit;
    logic                 r_commit;
    logic [DWIDTH-1:0]    r_shadow [CHANNELS];

    assign w_tick = (r_presc == c_presc_last);

    // Prescaler: one counter tick every CLK_DIV clock cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [DWIDTH-1:0] c_cnt_one = DWIDTH'(1);
    logic r_dir_up;

    // Triangle counter: up to the maximum, then back down to zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
        end else if (w_tick) begin
            if (r_dir_up) begin
                if (r_cnt == c_cnt_max) begin
                    r_cnt    <= r_cnt - 1'b1;
                    r_dir_up <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == c_cnt_one) begin
                    r_dir_up <= 1'b1;
                end
            end
        end
    end

    // Period boundary is the downward step onto zero
    assign w_wrap = w_tick && !r_dir_up && (r_cnt == c_cnt_one);
`else
    // Sawtooth counter: free-running modulo 2^DWIDTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Period boundary is the wrap from maximum back to zero
    assign w_wrap = w_tick && (r_cnt == c_cnt_max);
`endif

    // Pulse flags aligned with the cycle in which the counter reads zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_period_start <= 1'b0;
            r_commit       <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            r_commit       <= w_commit;
        end
    end

    // Load FSM state and channel index registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Load FSM next state; start always restarts a frame and beats data
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end
            end
            LOAD: begin
                if (start) begin
                    w_idx_nxt = '0;
                end else if (data_valid) begin
                    w_wr_en = 1'b1;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = PEND;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            PEND: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end else if (w_wrap) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Shadow bank, written one word per accepted beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_shadow[r_idx] <= data;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        pwm_channel #(
            .DWIDTH (DWIDTH)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .load    (w_commit),
            .duty_in (r_shadow[g]),
            .cnt     (r_cnt),
            .out     (out[g])
        );
    end

    assign load_ready   = (r_state == LOAD);
    assign commit       = r_commit;
    assign period_start = r_period_start;

endmodule : pwm_multi
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi
//  Description : Self-checking bench for pwm_multi (DWIDTH=4, CHANNELS=3),
//                one instance with CLK_DIV=1 and one with CLK_DIV=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

`ifdef PWM_CENTER_ALIGN_EN
    localparam int c_p = 30;
`else
    localparam int c_p = 16;
`endif
    localparam int c_p3 = 3 * c_p;

    logic       clk;
    logic       rst, start, data_valid;
    logic [3:0] data;
    logic       load_ready, commit, period_start;
    logic [2:0] out;

    logic       rst3, start3, dv3;
    logic [3:0] data3;
    logic       lr3, commit3, ps3;
    logic [2:0] out3;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] d0, d1, d2;
        int         h0, h1, h2;
    } vec_t;
    vec_t vecs [3];

    pwm_multi #(.DWIDTH(4), .CHANNELS(3), .CLK_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .data_valid(data_valid),
        .load_ready(load_ready), .commit(commit), .period_start(period_start), .out(out)
    );

    pwm_multi #(.DWIDTH(4), .CHANNELS(3), .CLK_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .data(data3), .data_valid(dv3),
        .load_ready(lr3), .commit(commit3), .period_start(ps3), .out(out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        start = 1'b1; tick(); start = 1'b0;
        data_valid = 1'b1;
        data = a; tick();
        data = b; tick();
        data = c; tick();
        data_valid = 1'b0;
    endtask

    // Leaves the bench sampling the commit cycle
    task automatic wait_commit(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * c_p + 8 && !seen; i++) begin
            if (commit) seen = 1'b1;
            else        tick();
        end
        check(name, 32'(seen), 32'd1);
        check({name, "_ps"}, 32'(period_start), 32'd1);
    endtask

    task automatic wait_ps(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * c_p + 8 && !seen; i++) begin
            if (period_start) seen = 1'b1;
            else              tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Called at a period_start cycle; counts high cycles over one full period
    task automatic measure(input string name, input int e0, input int e1, input int e2,
                           output int ncommit);
        int h0 = 0, h1 = 0, h2 = 0;
        ncommit = 0;
        tick();
        check({name, "_rise"}, 32'(out), {29'd0, e2 > 0, e1 > 0, e0 > 0});
        for (int k = 0; k < c_p; k++) begin
            h0 += int'(out[0]);
            h1 += int'(out[1]);
            h2 += int'(out[2]);
            if (commit) ncommit++;
            if (k < c_p - 1) tick();
        end
        check({name, "_h0"}, 32'(h0), 32'(e0));
        check({name, "_h1"}, 32'(h1), 32'(e1));
        check({name, "_h2"}, 32'(h2), 32'(e2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc;
        int cyc, hi, ncom;
        bit seen;

`ifdef PWM_CENTER_ALIGN_EN
        vecs[0] = '{4'd4,  4'd8,  4'd15, 7,  15, 29};
        vecs[1] = '{4'd0,  4'd15, 4'd7,  0,  29, 13};
        vecs[2] = '{4'd10, 4'd1,  4'd12, 19, 1,  23};
`else
        vecs[0] = '{4'd4,  4'd8,  4'd15, 4,  8,  15};
        vecs[1] = '{4'd0,  4'd15, 4'd7,  0,  15, 7};
        vecs[2] = '{4'd10, 4'd1,  4'd12, 10, 1,  12};
`endif
        rst = 1'b0; start = 1'b0; data_valid = 1'b0; data = '0;
        rst3 = 1'b0; start3 = 1'b0; dv3 = 1'b0; data3 = '0;
        tick(); tick();

        // Reset state
        check("rst_out", 32'(out), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_ps", 32'(period_start), 32'd0);
        check("rst3_out", 32'(out3), 32'd0);
        rst = 1'b1; rst3 = 1'b1;
        tick();

        // Table-driven full frames
        for (int v = 0; v < 3; v++) begin
            load_frame(vecs[v].d0, vecs[v].d1, vecs[v].d2);
            wait_commit($sformatf("vec%0d_commit", v));
            measure($sformatf("vec%0d", v), vecs[v].h0, vecs[v].h1, vecs[v].h2, nc);
        end

        // Partial frame is never committed; output keeps the last frame
        start = 1'b1; tick(); start = 1'b0;
        data_valid = 1'b1; data = 4'd3; tick(); data = 4'd3; tick(); data_valid = 1'b0;
        ncom = 0;
        for (int k = 0; k < 3 * c_p; k++) begin
            if (commit) ncom++;
            tick();
        end
        check("partial_no_commit", 32'(ncom), 32'd0);
        wait_ps("partial_ps");
        measure("partial_keep", vecs[2].h0, vecs[2].h1, vecs[2].h2, nc);
        load_frame(4'd1, 4'd2, 4'd3);
        wait_commit("frame123_commit");
`ifdef PWM_CENTER_ALIGN_EN
        measure("frame123", 1, 3, 5, nc);
`else
        measure("frame123", 1, 2, 3, nc);
`endif

        // Pending frame abandoned by start; start beats data_valid in LOAD
        tick();
        wait_ps("abandon_ps");
        load_frame(4'd5, 4'd5, 4'd5);
        start = 1'b1; tick(); start = 1'b0;
        check("abandon_ready", 32'(load_ready), 32'd1);
        data_valid = 1'b1; data = 4'd3; tick();
        start = 1'b1; data = 4'd7; tick(); start = 1'b0;
        data = 4'd9; tick(); tick(); tick();
        data_valid = 1'b0;
        check("abandon_pend_ready", 32'(load_ready), 32'd0);
        wait_commit("abandon_commit");
`ifdef PWM_CENTER_ALIGN_EN
        measure("abandon", 17, 17, 17, nc);
`else
        measure("abandon", 9, 9, 9, nc);
`endif
        check("abandon_single_commit", 32'(nc), 32'd0);

        // Prescaled instance: period length, high count, mid-period reset
        start3 = 1'b1; tick(); start3 = 1'b0;
        dv3 = 1'b1;
        data3 = 4'd6; tick(); data3 = 4'd0; tick(); data3 = 4'd12; tick();
        dv3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * c_p3 + 8 && !seen; i++) begin
            if (commit3) seen = 1'b1;
            else         tick();
        end
        check("div3_commit", 32'(seen), 32'd1);
        cyc = 0; hi = 0; seen = 1'b0;
        for (int i = 0; i < 2 * c_p3 && !seen; i++) begin
            tick();
            cyc++;
            hi += int'(out3[0]);
            if (ps3) seen = 1'b1;
        end
        check("div3_period", 32'(cyc), 32'(c_p3));
`ifdef PWM_CENTER_ALIGN_EN
        check("div3_high", 32'(hi), 32'd33);
`else
        check("div3_high", 32'(hi), 32'd18);
`endif
        for (int k = 0; k < 7; k++) tick();
        check("div3_pre_rst_out", 32'(out3), 32'b101);
        rst3 = 1'b0; tick();
        check("div3_rst_out", 32'(out3), 32'd0);
        check("div3_rst_cnt", 32'(u_dut3.r_cnt), 32'd0);
        check("div3_rst_ps", 32'(ps3), 32'd0);
        rst3 = 1'b1;
        hi = 0; ncom = 0;
        for (int k = 0; k < c_p3 + 5; k++) begin
            tick();
            hi += int'(out3 != 3'd0);
            if (commit3) ncom++;
        end
        check("div3_after_rst_high", 32'(hi), 32'd0);
        check("div3_after_rst_commit", 32'(ncom), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pwm_multi
`default_nettype wire
